// File: rtl/spi_xfer_pkg.sv
// Shared types and constants for the SPI mode-0 word transfer controller.
package spi_xfer_pkg;

   // Transfer sequencer states
   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      HOLD
   } spi_state_t;

   // Level MOSI presents out of reset, before any frame has run
   localparam logic MOSI_RST = 1'b0;

endpackage

// File: rtl/spi_xfer_ctrl_timer.sv
// Reloadable phase down-counter: TICK marks the last cycle of a DIV+1 cycle phase.
module spi_phase_timer #(
   parameter int DIV_W = 8
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             LOAD,
   input  logic [DIV_W-1:0] RELOAD,
   output logic             TICK
);

   logic [DIV_W-1:0] count;

   assign TICK = (count == '0);

   // Reload on explicit load or at terminal count, otherwise count down
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         count <= '0;
      else if (LOAD || TICK)
         count <= RELOAD;
      else
         count <= count - DIV_W'(1);
   end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode 0 (CPOL=0/CPHA=0), LSB-first, single chip-select word transfer.
// Optional macro SPI_XFER_MISO_SYNC_EN: MISO goes through a 2-flop
// synchronizer and is sampled 2 CLK after the SCK rise (needs DIV>=2).
module spi_xfer_ctrl
   import spi_xfer_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DIV_W = 8
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic [DIV_W-1:0] DIV,
   input  logic [DW-1:0]    TX_DATA,
   output logic [DW-1:0]    RX_DATA,
   output logic             BUSY,
   output logic             DONE,
   output logic             SCK,
   output logic             MOSI,
   input  logic             MISO,
   output logic             CS_N
);

   localparam int CW = $clog2(DW + 1);

   spi_state_t       state, state_nxt;
   logic [DIV_W-1:0] div_r;
   logic [DIV_W-1:0] reload;
   logic [DW-1:0]    tx_sr;
   logic [DW-1:0]    rx_sr;
   logic [CW-1:0]    bit_cnt;
   logic             load, tick, rise, fall, fin;
   logic             samp, samp_bit;

   // At frame start the divider register is not loaded yet, so use DIV directly
   assign reload = load ? DIV : div_r;

   spi_phase_timer #(.DIV_W(DIV_W)) u_timer (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .LOAD    (load),
      .RELOAD  (reload),
      .TICK    (tick)
   );

   // Next-state decode; each non-IDLE phase ends on the timer tick
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      rise      = 1'b0;
      fall      = 1'b0;
      fin       = 1'b0;
      case (state)
         IDLE:  if (START) begin state_nxt = SETUP; load = 1'b1; end
         SETUP: if (tick) begin state_nxt = HIGH; rise = 1'b1; end
         HIGH:  if (tick) begin
                   if (bit_cnt == CW'(DW)) state_nxt = HOLD;
                   else begin state_nxt = LOW; fall = 1'b1; end
                end
         LOW:   if (tick) begin state_nxt = HIGH; rise = 1'b1; end
         HOLD:  if (tick) begin state_nxt = IDLE; fin = 1'b1; end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef SPI_XFER_MISO_SYNC_EN
   logic [1:0] miso_s;
   logic [1:0] rise_d;

   // Synchronize MISO and delay the sample strobe to match its latency
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         miso_s <= '0;
         rise_d <= '0;
      end else begin
         miso_s <= {miso_s[0], MISO};
         rise_d <= {rise_d[0], rise};
      end
   end

   assign samp     = rise_d[1];
   assign samp_bit = miso_s[1];
`else
   assign samp     = rise;
   assign samp_bit = MISO;
`endif

   // MOSI is a flop output: the LSB of the shift-out register
   assign MOSI = tx_sr[0];

   // State, pin registers, shift registers and bit counter
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= IDLE;
         SCK     <= 1'b0;
         CS_N    <= 1'b1;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         RX_DATA <= '0;
         tx_sr   <= DW'(MOSI_RST);
         rx_sr   <= '0;
         div_r   <= '0;
         bit_cnt <= '0;
      end else begin
         state <= state_nxt;
         SCK   <= (state_nxt == HIGH);
         CS_N  <= (state_nxt == IDLE);
         BUSY  <= (state_nxt != IDLE);
         DONE  <= fin;
         if (load) begin
            tx_sr   <= TX_DATA;
            div_r   <= DIV;
            bit_cnt <= '0;
         end else if (fall) begin
            tx_sr <= tx_sr >> 1;
         end
         if (rise)
            bit_cnt <= bit_cnt + CW'(1);
         if (samp)
            rx_sr <= {samp_bit, rx_sr[DW-1:1]};
         if (fin)
            RX_DATA <= rx_sr;
      end
   end

endmodule
